// File: rtl/manual_rf_loader_pkg.sv
// Shared definitions for the front-panel register-file loader:
// state encodings (visible on LEDs) and chunk-count helpers.
package manual_rf_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_DATA        = 4'd1,
    ST_WRITE       = 4'd2,
    ST_START       = 4'd3,
    ST_WAIT_RENDER = 4'd4,
    ST_DONE        = 4'd5,
    ST_ERR         = 4'd15
  } state_e;

  // Number of switch-bank presses needed to build one data word.
  function automatic int calc_num_chunks(input int data_w, input int chunk_w);
    return (data_w + chunk_w - 1) / chunk_w;
  endfunction

  // Width of the chunk index; one extra bit so it can hold NUM_CHUNKS itself.
  function automatic int calc_chunk_idx_w(input int num_chunks);
    return $clog2(num_chunks) + 1;
  endfunction

endpackage

// File: rtl/manual_rf_loader_if.sv
// Register-file write port plus renderer start/done handshake.
//
// Handshake: rr_start is a one-cycle request pulse from the loader; the
// renderer answers with rr_done (a pulse or a held level), which the loader
// accepts in any cycle it is waiting. The write port is fire-and-forget:
// rf_w_en high for one cycle commits rf_w_addr/rf_w_data.
interface manual_rf_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  logic              rf_w_en;
  logic [ADDR_W-1:0] rf_w_addr;
  logic [DATA_W-1:0] rf_w_data;
  logic              rr_start;
  logic              rr_done;

  modport master (
    output rf_w_en, rf_w_addr, rf_w_data, rr_start,
    input  rr_done
  );

  modport slave (
    input  rf_w_en, rf_w_addr, rf_w_data, rr_start,
    output rr_done
  );
endinterface

// File: rtl/manual_rf_loader_key_debounce.sv
// Raw active-low push button -> 2-flop synchroniser -> counter debouncer ->
// one-cycle press pulse on the debounced released-to-pressed transition.
module manual_rf_loader_key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise, then flip the debounced level only after DEBOUNCE_CYC
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_key_n;
      r_sync1 <= r_sync0;
      r_press <= 1'b0;
      if (r_sync1 != r_level) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
          r_level <= r_sync1;
          r_cnt   <= '0;
          r_press <= ~r_sync1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/manual_rf_loader.sv
// Front-panel loader: an address press, then NUM_CHUNKS data presses build a
// word; one register-file write (suppressed for x0), then a renderer
// start/done handshake guarded by a timeout with a sticky error flag.
module manual_rf_loader
  import manual_rf_loader_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int SW_W           = 10,
  parameter int CHUNK_W        = 8,
  parameter int DEBOUNCE_CYC   = 500000,
  parameter int RENDER_TIMEOUT = 2**22,
  localparam int NUM_CHUNKS    = calc_num_chunks(DATA_W, CHUNK_W),
  localparam int CIDX_W        = calc_chunk_idx_w(NUM_CHUNKS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_W-1:0]     sw,
  input  logic                enter_key_n,
  input  logic                cancel_key_n,
  manual_rf_loader_if.master  bus,
  output logic                busy,
  output logic                error,
  output logic [CIDX_W-1:0]   chunk_idx,
  output logic [3:0]          state_dbg
);

  localparam int TO_W = (RENDER_TIMEOUT > 1) ? $clog2(RENDER_TIMEOUT) : 1;
  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NUM_CHUNKS - 1);
  localparam logic [TO_W-1:0]   LAST_TICK  = TO_W'(RENDER_TIMEOUT - 1);

  state_e            r_state;
  logic              r_w_en;
  logic              r_start;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CIDX_W-1:0] r_idx;
  logic [TO_W-1:0]   r_timer;
  logic              r_busy;
  logic              r_error;

  logic              w_enter;
  logic              w_cancel;
  logic [DATA_W-1:0] w_data_next;
  logic              w_unused_sw;

  manual_rf_loader_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_enter_db (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (enter_key_n),
    .o_press (w_enter)
  );

  manual_rf_loader_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cancel_db (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (cancel_key_n),
    .o_press (w_cancel)
  );

  // Merge the current switch chunk into the word at the slot selected by
  // r_idx; bits that would land at or above DATA_W simply have no home.
  always_comb begin
    w_data_next = r_data;
    for (int b = 0; b < DATA_W; b++) begin
      if (r_idx == CIDX_W'(b / CHUNK_W)) begin
        w_data_next[b] = sw[b % CHUNK_W];
      end
    end
  end

  // Sequencer; outputs are registered and set on the transition into the
  // state they belong to. Cancel beats enter whenever both fire together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_w_en  <= 1'b0;
      r_start <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_w_en  <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_enter && !w_cancel) begin
            r_addr  <= sw[ADDR_W-1:0];
            r_data  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_cancel) begin
            r_data  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_enter) begin
            r_data <= w_data_next;
            r_idx  <= r_idx + 1'b1;
            if (r_idx == LAST_CHUNK) begin
              r_w_en  <= (r_addr != '0);
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          r_start <= 1'b1;
          r_state <= ST_START;
        end
        ST_START: begin
          r_timer <= '0;
          r_state <= ST_WAIT_RENDER;
        end
        ST_WAIT_RENDER: begin
          if (bus.rr_done) begin
            r_state <= ST_DONE;
          end else if (r_timer == LAST_TICK) begin
            r_error <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DONE: begin
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          r_error <= 1'b1;
          if (w_cancel) begin
            r_error <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_error <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= ST_ERR;
        end
      endcase
    end
  end

  // Switch bits above both the address and chunk fields are never used.
  assign w_unused_sw = ^sw;

  assign bus.rf_w_en   = r_w_en;
  assign bus.rf_w_addr = r_addr;
  assign bus.rf_w_data = r_data;
  assign bus.rr_start  = r_start;
  assign busy          = r_busy;
  assign error         = r_error;
  assign chunk_idx     = r_idx;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_manual_rf_loader.sv
// Bench for manual_rf_loader with short debounce and render timeout.
module tb_manual_rf_loader;
  import manual_rf_loader_pkg::*;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int SW_W    = 10;
  localparam int CHUNK_W = 8;
  localparam int DB      = 4;
  localparam int TO      = 64;
  localparam int NCH     = calc_num_chunks(DATA_W, CHUNK_W);
  localparam int CIDX_W  = calc_chunk_idx_w(NCH);

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [SW_W-1:0]   sw;
  logic              enter_key_n;
  logic              cancel_key_n;
  logic              busy;
  logic              error;
  logic [CIDX_W-1:0] chunk_idx;
  logic [3:0]        state_dbg;

  always #5 clk = ~clk;

  manual_rf_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  manual_rf_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SW_W(SW_W), .CHUNK_W(CHUNK_W),
    .DEBOUNCE_CYC(DB), .RENDER_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .enter_key_n  (enter_key_n),
    .cancel_key_n (cancel_key_n),
    .bus          (bus),
    .busy         (busy),
    .error        (error),
    .chunk_idx    (chunk_idx),
    .state_dbg    (state_dbg)
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- monitor (negedge) ----------------
  logic [ADDR_W+DATA_W-1:0] obs_q[$];
  int cyc = 0;
  int w_cyc = 0;
  int s_cyc = 0;
  int start_cnt = 0;
  int wait_cycles = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.rf_w_en === 1'b1) begin
      obs_q.push_back({bus.rf_w_addr, bus.rf_w_data});
      w_cyc = cyc;
    end
    if (bus.rr_start === 1'b1) begin
      start_cnt++;
      s_cyc = cyc;
    end
    if (state_dbg == 4'd4) wait_cycles++;
  end

  // ---------------- renderer responder ----------------
  bit resp_en = 1'b0;
  int done_delay = 1;
  int resp_cnt = 0;

  always @(negedge clk) begin
    bus.rr_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) bus.rr_done = 1'b1;
    end
    if (bus.rr_start === 1'b1 && resp_en) resp_cnt = done_delay;
  end

  // ---------------- reference model ----------------
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  bit                m_in_seq = 1'b0;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_chunks[$];
  int                m_starts = 0;
  int                obs_rd = 0;
  int                exp_rd = 0;

  // An accepted enter: first one latches the address, later ones append
  // chunks; a full set of chunks produces a write (unless x0) and a render.
  task automatic model_enter(input logic [SW_W-1:0] s);
    logic [DATA_W-1:0] d;
    if (!m_in_seq) begin
      m_in_seq = 1'b1;
      m_addr   = s[ADDR_W-1:0];
      m_chunks.delete();
    end else begin
      m_chunks.push_back(s[CHUNK_W-1:0]);
      if (m_chunks.size() == NCH) begin
        d = '0;
        foreach (m_chunks[i]) d = d | (DATA_W'(m_chunks[i]) << (CHUNK_W * i));
        if (m_addr != 0) exp_q.push_back({m_addr, d});
        m_starts++;
        m_in_seq = 1'b0;
      end
    end
  endtask

  task automatic model_cancel();
    m_in_seq = 1'b0;
  endtask

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input bit en, input bit ca);
    enter_key_n  = ~en;
    cancel_key_n = ~ca;
    repeat (8) tick();
    enter_key_n  = 1'b1;
    cancel_key_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic wait_state(input string tag, input logic [3:0] target, input int max_cyc);
    for (int i = 0; i < max_cyc && state_dbg !== target; i++) tick();
    chk(tag, state_dbg, target);
  endtask

  task automatic enter_addr(input string tag, input logic [ADDR_W-1:0] addr);
    sw = SW_W'($urandom);
    sw[ADDR_W-1:0] = addr;
    press(1'b1, 1'b0);
    model_enter(sw);
    chk({tag, "_st_data"}, state_dbg, 4'd1);
    chk({tag, "_addr"}, bus.rf_w_addr, addr);
    chk({tag, "_cidx0"}, chunk_idx, 0);
  endtask

  task automatic enter_chunk(input string tag, input logic [CHUNK_W-1:0] c);
    sw = SW_W'($urandom);
    sw[CHUNK_W-1:0] = c;
    press(1'b1, 1'b0);
    model_enter(sw);
  endtask

  task automatic do_seq(input string tag, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input int dly, input bit en);
    resp_en    = en;
    done_delay = dly;
    enter_addr(tag, addr);
    for (int c = 0; c < NCH; c++) begin
      enter_chunk(tag, data[c*CHUNK_W +: CHUNK_W]);
      if (c < NCH - 1) chk({tag, "_cidx"}, chunk_idx, c + 1);
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wcount"}, obs_q.size() - obs_rd, exp_q.size() - exp_rd);
    while (exp_rd < exp_q.size() && obs_rd < obs_q.size()) begin
      chk({tag, "_wdata"}, obs_q[obs_rd], exp_q[exp_rd]);
      obs_rd++;
      exp_rd++;
    end
    obs_rd = obs_q.size();
    exp_rd = exp_q.size();
    chk({tag, "_starts"}, start_cnt, m_starts);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    int wait_base;

    rst = 1'b1; enter_key_n = 1'b1; cancel_key_n = 1'b1; sw = '0;
    repeat (3) tick();
    chk("rst_state", state_dbg, 4'd0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_cidx", chunk_idx, 0);
    chk("rst_wen", bus.rf_w_en, 0);
    chk("rst_start", bus.rr_start, 0);
    chk("rst_addr", bus.rf_w_addr, 0);
    chk("rst_data", bus.rf_w_data, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic load: addr 5, data 0x12345678, done 10 cycles after start.
    do_seq("t1", 5'd5, 32'h12345678, 10, 1'b1);
    wait_state("t1_idle", 4'd0, 200);
    chk("t1_busy", busy, 0);
    chk("t1_cidx", chunk_idx, 0);
    check_writes("t1");
    chk("t1_w_to_start", s_cyc - w_cyc, 1);
    chk("t1_addr_hold", bus.rf_w_addr, 5);
    chk("t1_data_hold", bus.rf_w_data, 32'h12345678);

    // x0 write suppression; render still started.
    do_seq("t2", 5'd0, $urandom, 5, 1'b1);
    wait_state("t2_idle", 4'd0, 200);
    check_writes("t2");

    // Glitches and bounce produce no press; a stable 6-cycle low does.
    sw = 10'd9;
    enter_key_n = 1'b0; repeat (2) tick();
    enter_key_n = 1'b1; repeat (10) tick();
    for (int i = 0; i < 12; i++) begin
      enter_key_n = ~enter_key_n;
      tick();
    end
    enter_key_n = 1'b1; repeat (10) tick();
    chk("t3_no_event", state_dbg, 4'd0);
    enter_key_n = 1'b0; repeat (6) tick();
    enter_key_n = 1'b1; repeat (10) tick();
    model_enter(sw);
    chk("t3_one_event", state_dbg, 4'd1);
    chk("t3_one_cidx", chunk_idx, 0);
    chk("t3_addr", bus.rf_w_addr, 9);
    press(1'b0, 1'b1);
    model_cancel();
    chk("t3_cancel", state_dbg, 4'd0);

    // Cancel after two chunks, then a clean load.
    resp_en = 1'b1;
    enter_addr("t4", 5'd3);
    enter_chunk("t4", 8'h11);
    enter_chunk("t4", 8'h22);
    chk("t4_cidx2", chunk_idx, 2);
    press(1'b0, 1'b1);
    model_cancel();
    chk("t4_idle", state_dbg, 4'd0);
    chk("t4_cidx", chunk_idx, 0);
    chk("t4_data_clr", bus.rf_w_data, 0);
    check_writes("t4a");
    do_seq("t4b", 5'd7, 32'hAABBCCDD, 3, 1'b1);
    wait_state("t4b_idle", 4'd0, 200);
    check_writes("t4b");

    // Render timeout -> ERR; enter ignored; cancel clears.
    wait_base = wait_cycles;
    do_seq("t5", 5'd9, $urandom, 1, 1'b0);
    wait_state("t5_err", 4'd15, 300);
    chk("t5_wait_len", wait_cycles - wait_base, TO);
    chk("t5_error", error, 1);
    chk("t5_busy", busy, 1);
    press(1'b1, 1'b0);
    chk("t5_enter_ign", state_dbg, 4'd15);
    chk("t5_error_hold", error, 1);
    press(1'b0, 1'b1);
    chk("t5_idle", state_dbg, 4'd0);
    chk("t5_error_clr", error, 0);
    check_writes("t5");

    // Enter and cancel together in DATA: cancel wins.
    enter_addr("t6", 5'd2);
    enter_chunk("t6", 8'h5A);
    press(1'b1, 1'b1);
    model_cancel();
    chk("t6_both_idle", state_dbg, 4'd0);
    chk("t6_both_cidx", chunk_idx, 0);
    chk("t6_both_data", bus.rf_w_data, 0);

    // Reset in WAIT_RENDER.
    do_seq("t7", 5'd11, $urandom, 1, 1'b0);
    wait_state("t7_wait", 4'd4, 50);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_cancel();
    chk("t7_state", state_dbg, 4'd0);
    chk("t7_busy", busy, 0);
    chk("t7_error", error, 0);
    chk("t7_cidx", chunk_idx, 0);
    chk("t7_wen", bus.rf_w_en, 0);
    chk("t7_start", bus.rr_start, 0);
    chk("t7_addr", bus.rf_w_addr, 0);
    chk("t7_data", bus.rf_w_data, 0);
    repeat (80) tick();
    chk("t7_stay_idle", state_dbg, 4'd0);
    check_writes("t7");

    // Random loads.
    for (int k = 0; k < 5; k++) begin
      ra = ADDR_W'($urandom_range(0, 31));
      rd = $urandom;
      do_seq("rnd", ra, rd, $urandom_range(1, 30), 1'b1);
      wait_state("rnd_idle", 4'd0, 200);
      check_writes("rnd");
      if (ra != 0) begin
        chk("rnd_w_to_start", s_cyc - w_cyc, 1);
        chk("rnd_data_hold", bus.rf_w_data, rd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
